complex_counter_n: RTL and testbench

- Parametrised successor to the 4-bit multi-mode counter: a WIDTH-bit counter with eight selectable sequences (binary up/down, Gray, BCD, Johnson, ring, ping-pong, hold).
- Adds a synchronous parallel load, a terminal-count flag and a registered wrap pulse.
- Used as a general timing/sequence source in lab datapaths and as a cascadable stage: Wrap of one instance drives Enable of the next.

---
 rtl/complex_counter_n.sv | 197 +++++++++++++++++++
 tb/tb_complex_counter_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/complex_counter_n.sv
// WIDTH-bit multi-sequence counter: up/down/gray/bcd/johnson/ring/pingpong/hold,
// with enabled parallel load, combinational terminal-count flag and registered wrap pulse.
module complex_counter_n #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [2:0]  RESET_MODE = 3'd0
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Enable,
    input  logic [2:0]       Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Count,
    output logic [2:0]       ActiveMode,
    output logic             TC,
    output logic             Wrap
);

    typedef enum logic [2:0] {
        M_UP   = 3'd0,
        M_DOWN = 3'd1,
        M_GRAY = 3'd2,
        M_BCD  = 3'd3,
        M_JOHN = 3'd4,
        M_RING = 3'd5,
        M_PING = 3'd6,
        M_HOLD = 3'd7
    } mode_e;

    localparam int unsigned      NDIG = WIDTH / 4;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB  = ONE << (WIDTH - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    mode_e            mode_q, mode_d;
    logic             dir_up_q, dir_up_d;
    logic             wrap_q, wrap_d;

    logic             tc_c;
    logic             all_nines_c;
    logic             bcd_carry_c;
    logic [WIDTH-1:0] bcd_next_c;
    logic [WIDTH-1:0] bin_inc_c;
    logic [WIDTH-1:0] step_cnt_c;
    logic [WIDTH-1:0] step_bin_c;
    logic             step_dir_c;
    logic [WIDTH-1:0] seed_cnt_c;
    logic [WIDTH-1:0] seed_bin_c;
    mode_e            req_mode_c;

    assign req_mode_c = mode_e'(Mode);
    assign bin_inc_c  = bin_q + ONE;

    // Decimal ripple increment; any digit >= 9 rolls to 0 and carries onward.
    always_comb begin
        all_nines_c = 1'b1;
        bcd_carry_c = 1'b1;
        bcd_next_c  = count_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (count_q[4*i +: 4] != 4'd9) all_nines_c = 1'b0;
            if (bcd_carry_c) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    bcd_next_c[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next_c[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    bcd_carry_c          = 1'b0;
                end
            end
        end
    end

    // Terminal value of the sequence currently in effect.
    always_comb begin
        tc_c = 1'b0;
        unique case (mode_q)
            M_UP:    tc_c = (count_q == ONES);
            M_DOWN:  tc_c = (count_q == ZERO);
            M_GRAY:  tc_c = (bin_q == ONES);
            M_BCD:   tc_c = all_nines_c;
            M_JOHN:  tc_c = (count_q == MSB);
            M_RING:  tc_c = (count_q == MSB);
            M_PING:  tc_c = (dir_up_q && count_q == ONES) || (!dir_up_q && count_q == ZERO);
            M_HOLD:  tc_c = 1'b0;
            default: tc_c = 1'b0;
        endcase
    end

    // One step of the active sequence.
    always_comb begin
        step_cnt_c = count_q;
        step_dir_c = dir_up_q;
        unique case (mode_q)
            M_UP:    step_cnt_c = count_q + ONE;
            M_DOWN:  step_cnt_c = count_q - ONE;
            M_GRAY:  step_cnt_c = bin_inc_c ^ (bin_inc_c >> 1);
            M_BCD:   step_cnt_c = bcd_next_c;
            M_JOHN:  step_cnt_c = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            M_RING:  step_cnt_c = (count_q == ZERO) ? ONE : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            M_PING: begin
                if (dir_up_q) begin
                    if (count_q == ONES) begin
                        step_cnt_c = count_q - ONE;
                        step_dir_c = 1'b0;
                    end else begin
                        step_cnt_c = count_q + ONE;
                    end
                end else begin
                    if (count_q == ZERO) begin
                        step_cnt_c = count_q + ONE;
                        step_dir_c = 1'b1;
                    end else begin
                        step_cnt_c = count_q - ONE;
                    end
                end
            end
            M_HOLD:  step_cnt_c = count_q;
            default: step_cnt_c = count_q;
        endcase
        step_bin_c = (mode_q == M_GRAY) ? bin_inc_c : step_cnt_c;
    end

    // Starting value when switching into a new sequence.
    always_comb begin
        seed_cnt_c = ZERO;
        seed_bin_c = ZERO;
        unique case (req_mode_c)
            M_DOWN: begin
                seed_cnt_c = ONES;
                seed_bin_c = ONES;
            end
            M_RING: begin
                seed_cnt_c = ONE;
                seed_bin_c = ONE;
            end
            M_HOLD: begin
                seed_cnt_c = count_q;
                seed_bin_c = bin_q;
            end
            default: begin
                seed_cnt_c = ZERO;
                seed_bin_c = ZERO;
            end
        endcase
    end

    // Next state: load beats mode change beats step.
    always_comb begin
        count_d  = count_q;
        bin_d    = bin_q;
        mode_d   = mode_q;
        dir_up_d = dir_up_q;
        wrap_d   = 1'b0;
        if (Enable) begin
            if (Load) begin
                bin_d    = LoadValue;
                mode_d   = req_mode_c;
                dir_up_d = 1'b1;
                count_d  = (req_mode_c == M_GRAY) ? (LoadValue ^ (LoadValue >> 1)) : LoadValue;
            end else if (req_mode_c != mode_q) begin
                mode_d   = req_mode_c;
                count_d  = seed_cnt_c;
                bin_d    = seed_bin_c;
                dir_up_d = 1'b1;
            end else begin
                count_d  = step_cnt_c;
                bin_d    = step_bin_c;
                dir_up_d = step_dir_c;
                wrap_d   = tc_c;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count_q  <= (RESET_MODE == 3'd5) ? ONE : ZERO;
            bin_q    <= ZERO;
            mode_q   <= mode_e'(RESET_MODE);
            dir_up_q <= 1'b1;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            bin_q    <= bin_d;
            mode_q   <= mode_d;
            dir_up_q <= dir_up_d;
            wrap_q   <= wrap_d;
        end
    end

    assign Count      = count_q;
    assign ActiveMode = mode_q;
    assign TC         = tc_c;
    assign Wrap       = wrap_q;

endmodule

// File: tb/tb_complex_counter_n.sv
// Directed bench for complex_counter_n (WIDTH=4): expectations queued per step, checked after each edge.
module tb_complex_counter_n;

    logic       Clk;
    logic       nReset;
    logic       Enable;
    logic [2:0] Mode;
    logic       Load;
    logic [3:0] LoadValue;
    logic [3:0] Count;
    logic [2:0] ActiveMode;
    logic       TC;
    logic       Wrap;

    typedef struct packed {
        logic [3:0] cnt;
        logic [2:0] md;
        logic       tc;
        logic       wr;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [3:0] jseq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    complex_counter_n #(.WIDTH(4), .RESET_MODE(3'd0)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Enable     (Enable),
        .Mode       (Mode),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .Count      (Count),
        .ActiveMode (ActiveMode),
        .TC         (TC),
        .Wrap       (Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [2:0] m, input logic t, input logic w);
        exp_t e;
        e.cnt = c;
        e.md  = m;
        e.tc  = t;
        e.wr  = w;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_queue_empty"}, 8'd0, 8'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_count"}, 8'(Count), 8'(e.cnt));
            chk({tag, "_mode"},  8'(ActiveMode), 8'(e.md));
            chk({tag, "_tc"},    8'(TC), 8'(e.tc));
            chk({tag, "_wrap"},  8'(Wrap), 8'(e.wr));
        end
    endtask

    // Drive one cycle of inputs, queue what the DUT must show after the edge, then compare.
    task automatic step(input string tag, input logic en, input logic [2:0] md, input logic ld,
                        input logic [3:0] lv, input logic [3:0] ec, input logic [2:0] em,
                        input logic et, input logic ew);
        Enable    = en;
        Mode      = md;
        Load      = ld;
        LoadValue = lv;
        push(ec, em, et, ew);
        @(posedge Clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        logic [3:0] b;
        logic [3:0] v;
        nReset    = 1'b0;
        Enable    = 1'b0;
        Mode      = 3'd0;
        Load      = 1'b0;
        LoadValue = 4'd0;

        #2;
        push(4'h0, 3'd0, 1'b0, 1'b0);
        pop_check("reset");
        @(posedge Clk);
        #2;
        nReset = 1'b1;
        @(posedge Clk);
        #1;

        // Up: 0..15 then wrap to 0
        for (int k = 1; k <= 16; k++) begin
            v = 4'(k % 16);
            step("up", 1'b1, 3'd0, 1'b0, 4'd0, v, 3'd0, (v == 4'hF), (k == 16));
        end

        // BCD: seed, 0..9, wrap, then out-of-range load
        step("bcd_seed", 1'b1, 3'd3, 1'b0, 4'd0, 4'h0, 3'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            v = 4'(k % 10);
            step("bcd", 1'b1, 3'd3, 1'b0, 4'd0, v, 3'd3, (v == 4'd9), (k == 10));
        end
        step("bcd_loadC", 1'b1, 3'd3, 1'b1, 4'hC, 4'hC, 3'd3, 1'b0, 1'b0);
        step("bcd_fromC", 1'b1, 3'd3, 1'b0, 4'd0, 4'h0, 3'd3, 1'b0, 1'b0);

        // Johnson
        step("john_seed", 1'b1, 3'd4, 1'b0, 4'd0, 4'h0, 3'd4, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step("john", 1'b1, 3'd4, 1'b0, 4'd0, jseq[k], 3'd4, (jseq[k] == 4'h8), (k == 7));
        end

        // Pingpong: 1..15, 14..0, 1
        step("ping_seed", 1'b1, 3'd6, 1'b0, 4'd0, 4'h0, 3'd6, 1'b0, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            v = (k <= 15) ? 4'(k) : ((k <= 30) ? 4'(30 - k) : 4'd1);
            step("ping", 1'b1, 3'd6, 1'b0, 4'd0, v, 3'd6, (k == 15 || k == 30), (k == 16 || k == 31));
        end

        // Down via load, then hold
        step("down_load", 1'b1, 3'd1, 1'b1, 4'd1, 4'h1, 3'd1, 1'b0, 1'b0);
        step("down_0",    1'b1, 3'd1, 1'b0, 4'd0, 4'h0, 3'd1, 1'b1, 1'b0);
        step("down_wrap", 1'b1, 3'd1, 1'b0, 4'd0, 4'hF, 3'd1, 1'b0, 1'b1);
        step("hold_seed", 1'b1, 3'd7, 1'b0, 4'd0, 4'hF, 3'd7, 1'b0, 1'b0);
        step("hold_step", 1'b1, 3'd7, 1'b0, 4'd0, 4'hF, 3'd7, 1'b0, 1'b0);

        // Gray: load 5 -> 0111, then binary 6..15, wrap to 0
        step("gray_load", 1'b1, 3'd2, 1'b1, 4'd5, 4'b0111, 3'd2, 1'b0, 1'b0);
        for (int k = 6; k <= 16; k++) begin
            b = 4'(k % 16);
            v = b ^ (b >> 1);
            step("gray", 1'b1, 3'd2, 1'b0, 4'd0, v, 3'd2, (b == 4'hF), (k == 16));
        end

        // Ring: seed 1, rotate, wrap, illegal zero recovers to 1
        step("ring_seed", 1'b1, 3'd5, 1'b0, 4'd0, 4'h1, 3'd5, 1'b0, 1'b0);
        step("ring_2",    1'b1, 3'd5, 1'b0, 4'd0, 4'h2, 3'd5, 1'b0, 1'b0);
        step("ring_4",    1'b1, 3'd5, 1'b0, 4'd0, 4'h4, 3'd5, 1'b0, 1'b0);
        step("ring_8",    1'b1, 3'd5, 1'b0, 4'd0, 4'h8, 3'd5, 1'b1, 1'b0);
        step("ring_wrap", 1'b1, 3'd5, 1'b0, 4'd0, 4'h1, 3'd5, 1'b0, 1'b1);
        step("ring_load0",1'b1, 3'd5, 1'b1, 4'd0, 4'h0, 3'd5, 1'b0, 1'b0);
        step("ring_fix",  1'b1, 3'd5, 1'b0, 4'd0, 4'h1, 3'd5, 1'b0, 1'b0);
        step("ring_2b",   1'b1, 3'd5, 1'b0, 4'd0, 4'h2, 3'd5, 1'b0, 1'b0);
        step("ring_4b",   1'b1, 3'd5, 1'b0, 4'd0, 4'h4, 3'd5, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        #2;
        nReset = 1'b0;
        #1;
        push(4'h0, 3'd0, 1'b0, 1'b0);
        pop_check("async_reset");
        #1;
        nReset = 1'b1;
        @(posedge Clk);
        #1;

        // Wrap must clear on a disabled edge; disabled edges freeze everything
        step("up_loadE", 1'b1, 3'd0, 1'b1, 4'hE, 4'hE, 3'd0, 1'b0, 1'b0);
        step("up_F",     1'b1, 3'd0, 1'b0, 4'd0, 4'hF, 3'd0, 1'b1, 1'b0);
        step("up_wrap",  1'b1, 3'd0, 1'b0, 4'd0, 4'h0, 3'd0, 1'b0, 1'b1);
        step("dis_wrap", 1'b0, 3'd0, 1'b0, 4'd0, 4'h0, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step("up_run", 1'b1, 3'd0, 1'b0, 4'd0, 4'(k), 3'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step("frozen", 1'b0, 3'd1, 1'b1, 4'd9, 4'h3, 3'd0, 1'b0, 1'b0);
        end

        if (sbq.size() != 0) chk("queue_drained", 8'(sbq.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
